// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit feeder slice.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_IDLE,
      GAP
   } txf_state_t;

   localparam int TXF_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO for the tx feeder: storage, wrapping pointers, level, full/empty and sticky overflow.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = TXF_DEPTH_DEFAULT,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reinicio,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow
);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push;
   logic              pop;

   // full is taken from the pre-edge level, so a pop in the same cycle never rescues a push
   assign full    = (level == (ADDR_W+1)'(DEPTH));
   assign empty   = (level == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or posedge reinicio) begin
      if (reinicio) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         if (wr_en && full) overflow <= 1'b1;
         case ({push, pop})
            2'b10:   level <= level + (ADDR_W+1)'(1);
            2'b01:   level <= level - (ADDR_W+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes and launches them one frame at a time into the UART transmitter.
// Build option UART_TXF_GAP_EN adds GAP_CYCLES idle cycles after every frame.
//
// state     | meaning
// IDLE      | waiting for a stored byte and an idle transmitter; pops and launches
// LAUNCH    | tx_start high for this single cycle
// WAIT_BUSY | waiting for the transmitter to report ocupado
// WAIT_IDLE | frame in flight; waiting for ocupado to drop
// GAP       | inter-frame idle countdown (UART_TXF_GAP_EN builds only)
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH      = TXF_DEPTH_DEFAULT,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int GAP_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reinicio,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_ocupado
);

`ifdef UART_TXF_GAP_EN
   localparam bit GAP_BUILT = 1'b1;
   localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   logic [GAP_W-1:0] gap_cnt;
`else
   localparam bit GAP_BUILT = 1'b0;
`endif
   localparam bit GAP_ON = GAP_BUILT && (GAP_CYCLES > 0);

   txf_state_t state;
   logic       pop;
   logic [7:0] head;

   assign pop = (state == IDLE) && !empty && !tx_ocupado;

   uart_byte_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clock    (clock),
      .reinicio (reinicio),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (head),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow)
   );

   always_ff @(posedge clock or posedge reinicio) begin
      if (reinicio) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
`ifdef UART_TXF_GAP_EN
         gap_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data  <= head;
                  tx_start <= 1'b1;
                  state    <= LAUNCH;
               end
            end
            LAUNCH: begin
               tx_start <= 1'b0;
               state    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_ocupado) state <= WAIT_IDLE;
            end
            WAIT_IDLE: begin
               if (!tx_ocupado) begin
                  state <= GAP_ON ? GAP : IDLE;
`ifdef UART_TXF_GAP_EN
                  // loaded with N-1 so GAP lasts exactly GAP_CYCLES cycles
                  gap_cnt <= GAP_W'(GAP_CYCLES - 1);
`endif
               end
            end
`ifdef UART_TXF_GAP_EN
            GAP: begin
               if (gap_cnt == '0) state <= IDLE;
               else               gap_cnt <= gap_cnt - GAP_W'(1);
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder driving a simple 1-cycle-per-bit transmitter model.
module tb_uart_tx_feeder;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
`ifdef UART_TXF_GAP_EN
   localparam int EXP_DELTA = 4;
`else
   localparam int EXP_DELTA = 2;
`endif

   logic          clock    = 1'b0;
   logic          reinicio = 1'b1;
   logic          wr_en    = 1'b0;
   logic [7:0]    wr_data  = 8'h00;
   logic          full, empty, overflow, tx_start, tx_ocupado;
   logic [AW:0]   level;
   logic [7:0]    tx_data;

   logic          force_busy = 1'b0;
   logic          tx_busy    = 1'b0;
   logic [9:0]    tx_sh      = 10'h3FF;
   logic [3:0]    tx_cnt     = 4'd0;
   logic          tx_line;

   int            checks   = 0;
   int            failures = 0;
   int            launches = 0;
   int            cyc      = 0;
   logic [7:0]    exp_q [$];

   logic          start_prev = 1'b0;
   logic          ocup_prev  = 1'b0;
   int            last_fall  = 0;
   bit            gap_check_en = 1'b0;
   int            gap_base   = 0;
   logic [9:0]    bits       = '0;
   int            bit_idx    = 0;
   logic [9:0]    line_bits  = '0;

   always #5 clock = ~clock;

   uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(2)) dut (
      .clock      (clock),
      .reinicio   (reinicio),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .full       (full),
      .empty      (empty),
      .level      (level),
      .overflow   (overflow),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_ocupado (tx_ocupado)
   );

   assign tx_ocupado = tx_busy | force_busy;
   assign tx_line    = tx_busy ? tx_sh[0] : 1'b1;

   // transmitter model: start, 8 data bits LSB first, stop; one cycle per bit
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (!tx_busy) begin
         if (tx_start) begin
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx_busy <= 1'b1;
            tx_cnt  <= 4'd0;
         end
      end else if (tx_cnt == 4'd9) begin
         tx_busy <= 1'b0;
      end else begin
         tx_sh  <= {1'b1, tx_sh[9:1]};
         tx_cnt <= tx_cnt + 4'd1;
      end
   end

   // monitor / scoreboard
   always @(negedge clock) begin
      if (!tx_ocupado && ocup_prev) last_fall = cyc;
      if (tx_start) begin
         checks++;
         if (start_prev) begin
            failures++;
            $display("FAIL start_pulse_width: tx_start high on consecutive cycles, required single cycle");
         end else begin
            checks++;
            if (ocup_prev) begin
               failures++;
               $display("FAIL launch_while_busy: tx_ocupado=1 at launch, required 0");
            end
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_launch: tx_data=%02h with no byte expected", tx_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (tx_data !== e) begin
                  failures++;
                  $display("FAIL launch_data: tx_data=%02h required %02h", tx_data, e);
               end
            end
            if (gap_check_en && launches > gap_base) begin
               checks++;
               if (cyc - last_fall != EXP_DELTA) begin
                  failures++;
                  $display("FAIL interframe_gap: %0d cycles from ocupado fall, required %0d",
                           cyc - last_fall, EXP_DELTA);
               end
            end
            launches++;
         end
      end
      if (tx_busy) begin
         bits[bit_idx] = tx_line;
         bit_idx++;
         if (bit_idx == 10) begin
            line_bits = bits;
            bit_idx   = 0;
         end
      end
      start_prev = tx_start;
      ocup_prev  = tx_ocupado;
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      step();
      reinicio = 1'b1;
      #1;
      chk("rst_level", 32'(level), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      exp_q.delete();
      step();
      reinicio = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !tx_ocupado && !tx_start) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         failures++;
         $display("FAIL drain_%s: %0d bytes still pending after %0d cycles, required 0",
                  name, exp_q.size(), n);
      end
      repeat (8) @(negedge clock);
   endtask

   initial begin
      logic [9:0] a5_line;
      int         base;
      a5_line = 10'b11_0100_1010;

      do_reset();

      // 1: single byte, latency and line waveform
      step(); wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
      step(); wr_en = 1'b0;
      @(negedge clock);
      chk("t1_no_start_yet", 32'(tx_start), 0);
      @(negedge clock);
      chk("t1_start", 32'(tx_start), 1);
      chk("t1_data", 32'(tx_data), 32'hA5);
      drain("t1");
      chk("t1_line", 32'(line_bits), 32'(a5_line));
      chk("t1_empty", 32'(empty), 1);
      chk("t1_data_held", 32'(tx_data), 32'hA5);

      // 2: burst of three, ordered frames, inter-frame spacing
      step(); force_busy = 1'b1; wr_en = 1'b1; wr_data = 8'h11; exp_q.push_back(8'h11);
      step(); wr_data = 8'h22; exp_q.push_back(8'h22);
      step(); wr_data = 8'h33; exp_q.push_back(8'h33);
      step(); wr_en = 1'b0;
      @(negedge clock);
      chk("t2_level3", 32'(level), 3);
      gap_base = launches;
      gap_check_en = 1'b1;
      step(); force_busy = 1'b0;
      drain("t2");
      gap_check_en = 1'b0;
      chk("t2_level0", 32'(level), 0);
      chk("t2_frames", 32'(launches - gap_base), 3);

      // 3: overfill while transmitter busy
      do_reset();
      force_busy = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         step(); wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
         if (i < DEPTH) exp_q.push_back(8'h30 + 8'(i));
      end
      step(); wr_en = 1'b0;
      @(negedge clock);
      chk("t3_full", 32'(full), 1);
      chk("t3_level", 32'(level), DEPTH);
      chk("t3_overflow", 32'(overflow), 1);
      base = launches;
      step(); force_busy = 1'b0;
      drain("t3");
      chk("t3_sent", 32'(launches - base), DEPTH);

      // 4: push at full in the same cycle as a pop
      do_reset();
      force_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         step(); wr_en = 1'b1; wr_data = 8'h40 + 8'(i); exp_q.push_back(8'h40 + 8'(i));
      end
      step(); wr_en = 1'b0;
      @(negedge clock);
      chk("t4_full", 32'(full), 1);
      chk("t4_no_overflow", 32'(overflow), 0);
      step(); force_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
      step(); wr_en = 1'b0;
      @(negedge clock);
      chk("t4_level", 32'(level), DEPTH - 1);
      chk("t4_overflow", 32'(overflow), 1);
      chk("t4_not_full", 32'(full), 0);
      drain("t4");

      // 5: reset mid-frame with bytes queued (overflow still set from 4)
      for (int i = 0; i < 4; i++) begin
         step(); wr_en = 1'b1; wr_data = 8'h50 + 8'(i);
         if (i == 0) exp_q.push_back(8'h50);
      end
      step(); wr_en = 1'b0;
      repeat (3) @(negedge clock);
      chk("t5_level3", 32'(level), 3);
      chk("t5_busy", 32'(tx_ocupado), 1);
      step(); reinicio = 1'b1;
      #1;
      chk("t5_rst_start", 32'(tx_start), 0);
      chk("t5_rst_level", 32'(level), 0);
      chk("t5_rst_empty", 32'(empty), 1);
      chk("t5_rst_overflow", 32'(overflow), 0);
      step(); reinicio = 1'b0;
      base = launches;
      repeat (30) @(negedge clock);
      chk("t5_no_launch", 32'(launches - base), 0);
      step(); wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
      step(); wr_en = 1'b0;
      drain("t5");
      chk("t5_one_launch", 32'(launches - base), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
